vc_alloc_rr: RTL and testbench
==============================

Name: vc_alloc_rr

Overview:
- Next-generation virtual-channel allocator for the router output stage.
- Tracks VC ownership and downstream buffer credits for every (output port, VC) pair.
- Selects a VC for the head flit's output port using a per-port round-robin pointer, or a fixed-priority pointer when round-robin is disabled.
- Sits between route computation and the switch allocator; a VC is offered only when it is unowned, unmasked and has at least one credit.

Parameters:
- NPORTS, 5, number of output ports; 2..8.
- NVCS, 2, VCs per port; 2..8.
- CREDITS, 4, downstream buffer depth per VC; 1..15. Counter width is CW = CLogB2(CREDITS)+1.
- RR_MODE, 1, 1 = round-robin VC pointer per port; 0 = static lowest-index-first.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  global state-update enable.
- mask  in  NPORTS*NVCS  per-VC eligibility; bit p*NVCS+v gates port p, VC v.
- oport  in  LOG_NPORTS  output port of the requesting head flit.
- allocate  in  1  commit the offered VC this cycle.
- next_vc  out  LOG_NVCS  offered VC; combinational.
- next_vc_valid  out  1  offer is valid; combinational.
- free  in  1  release a VC (tail flit sent).
- free_oport  in  LOG_NPORTS  port of the VC being released.
- free_vc  in  LOG_NVCS  VC being released.
- send  in  1  one flit forwarded downstream; consumes one credit.
- send_oport  in  LOG_NPORTS  port of the forwarded flit.
- send_vc  in  LOG_NVCS  VC of the forwarded flit.
- credit_ret  in  1  one credit returned from downstream.
- cred_oport  in  LOG_NPORTS  port of the returned credit.
- cred_vc  in  LOG_NVCS  VC of the returned credit.
- error  out  1  sticky protocol-error flag.

Behaviour:
- **Reset** (reset_n low, asynchronous): all VCs unowned; all credits = CREDITS; all pointers = 0; error = 0.
- **Eligibility:** elig[p][v] = ~owned & mask & (credit != 0).
- **Selection for port oport:**
  - Scan starts at ptr[oport] and proceeds upward, wrapping modulo NVCS; the first eligible VC becomes next_vc.
  - When RR_MODE = 0, ptr is held at 0.
  - next_vc_valid = 0 when no VC is eligible or oport >= NPORTS; next_vc = 0 in that case.
  - Zero-cycle latency from oport, mask and state to next_vc.
- **Commit:** allocate & next_vc_valid & enable causes, at the next edge:
  - owned[oport][next_vc] = 1;
  - ptr[oport] = (next_vc+1) mod NVCS, when RR_MODE = 1.
- allocate with next_vc_valid = 0 is ignored; it is not an error.
- **Free:** free & enable clears owned[free_oport][free_vc]. Freeing an unowned VC leaves state unchanged and sets error.
- **Credits:**
  - send decrements the addressed counter; credit_ret increments it.
  - Both on the same VC in the same cycle: no change.
  - send at count 0: count held at 0, error set.
  - credit_ret at CREDITS: count held, error set.
- **Out-of-range indices:** any free, send or credit_ret with port >= NPORTS is ignored and sets error.
- **No bypass:** a VC freed or credited in cycle N is offerable no earlier than cycle N+1. Allocate and free on the same VC in the same cycle cannot occur, because an owned VC is never offered.
- **Same-edge commits:** a send on the VC being allocated in the same cycle still decrements; all updates commit at the same edge.
- **enable = 0:** no state changes (ownership, credits, pointers, error all hold). Outputs keep tracking combinationally.
- **error:** sticky until reset.
- **Reset mid-operation:** all state returns to its reset values immediately. The combinational outputs reflect the reset state while reset_n is low.

Test Plan (NPORTS=5, NVCS=4, CREDITS=2, RR_MODE=1 unless stated):
- Post-reset, oport=3, mask all 1 -> next_vc=0, valid=1. Allocate on 3 consecutive cycles -> grants 0, 1, 2; ptr[3] becomes 3.
- All 4 VCs of port 1 allocated -> valid=0. Free VC2 in cycle N -> valid=0 in N, then next_vc=2 in N+1.
- Two sends on port 0 VC0 -> that VC is no longer offered (next_vc=1). A third send -> error=1. One credit_ret -> VC0 is offerable again if unowned.
- send and credit_ret on port 4 VC3 in the same cycle at count 2 -> count stays 2, error=0. credit_ret alone at 2 -> error=1.
- RR_MODE=0: allocate VC0, free VC0, allocate again -> VC0 granted both times. mask bit 0 cleared -> next_vc=1.
- enable=0 with allocate, free, send asserted for 3 cycles -> no state change. Assert reset_n low mid-run -> all VCs offered and error=0 immediately.

Source files
------------

// File: rtl/vc_alloc_rr.sv
// Virtual-channel allocator: tracks VC ownership and downstream credits per
// (output port, VC), and offers one free VC for the head flit's output port.
module vc_alloc_rr #(
  parameter  int NPORTS     = 5,
  parameter  int NVCS       = 2,
  parameter  int CREDITS    = 4,
  parameter  int RR_MODE    = 1,
  localparam int LOG_NPORTS = $clog2(NPORTS),
  localparam int LOG_NVCS   = $clog2(NVCS),
  localparam int CW         = $clog2(CREDITS) + 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [NPORTS*NVCS-1:0]   mask,
  input  logic [LOG_NPORTS-1:0]    oport,
  input  logic                     allocate,
  output logic [LOG_NVCS-1:0]      next_vc,
  output logic                     next_vc_valid,
  input  logic                     free,
  input  logic [LOG_NPORTS-1:0]    free_oport,
  input  logic [LOG_NVCS-1:0]      free_vc,
  input  logic                     send,
  input  logic [LOG_NPORTS-1:0]    send_oport,
  input  logic [LOG_NVCS-1:0]      send_vc,
  input  logic                     credit_ret,
  input  logic [LOG_NPORTS-1:0]    cred_oport,
  input  logic [LOG_NVCS-1:0]      cred_vc,
  output logic                     error
);

  localparam int            NSLOTS   = NPORTS * NVCS;
  localparam int            IW       = $clog2(NSLOTS);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [CW-1:0] ONE      = CW'(1);

  // Flat slot index p*NVCS+v, shared by the mask bits and all state arrays.
  function automatic logic [IW-1:0] slot(input logic [LOG_NPORTS-1:0] p,
                                         input logic [LOG_NVCS-1:0]   v);
    return IW'(int'(p) * NVCS + int'(v));
  endfunction

  function automatic logic in_range(input logic [LOG_NPORTS-1:0] p,
                                    input logic [LOG_NVCS-1:0]   v);
    return (int'(p) < NPORTS) && (int'(v) < NVCS);
  endfunction

  logic [NSLOTS-1:0]                owned_q, owned_d;
  logic [NSLOTS-1:0][CW-1:0]        credit_q, credit_d;
  logic [NPORTS-1:0][LOG_NVCS-1:0]  ptr_q, ptr_d;
  logic                             error_q, error_d;

  logic [NSLOTS-1:0] elig;
  logic [NSLOTS-1:0] send_hit, cred_hit;
  logic              free_ok, send_ok, cred_ok;
  logic [IW-1:0]     alloc_slot, free_slot, send_slot, cred_slot;
  logic [LOG_NVCS-1:0] ptr_sel;
  int                cand;

  assign free_ok    = in_range(free_oport, free_vc);
  assign send_ok    = in_range(send_oport, send_vc);
  assign cred_ok    = in_range(cred_oport, cred_vc);
  assign alloc_slot = slot(oport, next_vc);
  assign free_slot  = slot(free_oport, free_vc);
  assign send_slot  = slot(send_oport, send_vc);
  assign cred_slot  = slot(cred_oport, cred_vc);
  assign send_hit   = (send && send_ok)       ? (NSLOTS'(1) << send_slot) : '0;
  assign cred_hit   = (credit_ret && cred_ok) ? (NSLOTS'(1) << cred_slot) : '0;
  assign error      = error_q;

  always_comb begin
    for (int i = 0; i < NSLOTS; i++) begin
      elig[i] = ~owned_q[i] & mask[i] & (credit_q[i] != '0);
    end
  end

  // Scan runs from the farthest offset down so the VC nearest ptr wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_vc       = '0;
    next_vc_valid = 1'b0;
    ptr_sel       = '0;
    cand          = 0;
    if (int'(oport) < NPORTS) begin
      ptr_sel = ptr_q[oport];
      for (int k = NVCS - 1; k >= 0; k--) begin
        cand = (int'(ptr_sel) + k) % NVCS;
        if (elig[IW'(int'(oport) * NVCS + cand)]) begin
          next_vc       = LOG_NVCS'(cand);
          next_vc_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    owned_d  = owned_q;
    credit_d = credit_q;
    ptr_d    = ptr_q;
    error_d  = error_q;
    if (enable) begin
      if (allocate && next_vc_valid) begin
        owned_d[alloc_slot] = 1'b1;
        if (RR_MODE != 0) ptr_d[oport] = LOG_NVCS'((int'(next_vc) + 1) % NVCS);
      end
      if (free) begin
        if (free_ok && owned_q[free_slot]) owned_d[free_slot] = 1'b0;
        else                               error_d            = 1'b1;
      end
      if ((send && !send_ok) || (credit_ret && !cred_ok)) error_d = 1'b1;
      // A send and a credit return on the same VC cancel and never flag.
      for (int i = 0; i < NSLOTS; i++) begin
        if (send_hit[i] && !cred_hit[i]) begin
          if (credit_q[i] == '0) error_d     = 1'b1;
          else                   credit_d[i] = credit_q[i] - ONE;
        end else if (cred_hit[i] && !send_hit[i]) begin
          if (credit_q[i] == CRED_MAX) error_d     = 1'b1;
          else                         credit_d[i] = credit_q[i] + ONE;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the credit array is plain flops with a non-zero reset value, so it must be reset like any register.
      owned_q  <= '0;
      credit_q <= {NSLOTS{CRED_MAX}};
      ptr_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      // NOTE: state registers take non-blocking assignments; next-state logic above uses blocking.
      owned_q  <= owned_d;
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
      error_q  <= error_d;
    end
  end

endmodule

// File: tb/tb_vc_alloc_rr.sv
// Scoreboard bench for vc_alloc_rr: one round-robin and one fixed-priority
// instance (NPORTS=5, NVCS=4, CREDITS=2) share the same stimulus.
module tb_vc_alloc_rr;

  logic        clock = 1'b0;
  logic        reset_n, enable, allocate, free, send, credit_ret;
  logic [19:0] mask;
  logic [2:0]  oport, free_oport, send_oport, cred_oport;
  logic [1:0]  free_vc, send_vc, cred_vc;
  logic [1:0]  nv_rr, nv_st;
  logic        vld_rr, vld_st, err_rr, err_st;

  typedef struct packed {
    logic [1:0] vc;
    logic       valid;
    logic       err;
  } obs_t;

  typedef struct {
    string name;
    bit    st;
    obs_t  v;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  vc_alloc_rr #(.NPORTS(5), .NVCS(4), .CREDITS(2), .RR_MODE(1)) dut_rr (
    .clock(clock), .reset_n(reset_n), .enable(enable), .mask(mask), .oport(oport),
    .allocate(allocate), .next_vc(nv_rr), .next_vc_valid(vld_rr),
    .free(free), .free_oport(free_oport), .free_vc(free_vc),
    .send(send), .send_oport(send_oport), .send_vc(send_vc),
    .credit_ret(credit_ret), .cred_oport(cred_oport), .cred_vc(cred_vc),
    .error(err_rr)
  );

  vc_alloc_rr #(.NPORTS(5), .NVCS(4), .CREDITS(2), .RR_MODE(0)) dut_st (
    .clock(clock), .reset_n(reset_n), .enable(enable), .mask(mask), .oport(oport),
    .allocate(allocate), .next_vc(nv_st), .next_vc_valid(vld_st),
    .free(free), .free_oport(free_oport), .free_vc(free_vc),
    .send(send), .send_oport(send_oport), .send_vc(send_vc),
    .credit_ret(credit_ret), .cred_oport(cred_oport), .cred_vc(cred_vc),
    .error(err_st)
  );

  function automatic obs_t obs(bit st);
    return st ? {nv_st, vld_st, err_st} : {nv_rr, vld_rr, err_rr};
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("vc=%0d valid=%0b err=%0b", o.vc, o.valid, o.err);
  endfunction

  task automatic expect_out(string name, bit st, int vc, bit valid, bit err);
    exp_t x;
    x.name = name; x.st = st; x.v = {2'(vc), valid, err};
    exp_q.push_back(x);
  endtask

  task automatic clear_inputs();
    enable = 1'b1; allocate = 1'b0; free = 1'b0; send = 1'b0; credit_ret = 1'b0;
    free_oport = '0; free_vc = '0; send_oport = '0; send_vc = '0;
    cred_oport = '0; cred_vc = '0;
  endtask

  task automatic adv();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; clear_inputs(); mask = '1;
    adv(); reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear_inputs(); mask = '1; oport = 3'd3;
    expect_out("reset_rr", 0, 0, 1, 0);
    expect_out("reset_st", 1, 0, 1, 0);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv(); reset_n = 1'b1;
  endtask

  task automatic test_rr_alloc();
    oport = 3'd3; allocate = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expect_out($sformatf("rr_grant%0d", k), 0, k, 1, 0);
      @(negedge clock);
      while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
        if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
      adv();
    end
    allocate = 1'b0; free = 1'b1; free_oport = 3'd3; free_vc = 2'd0;
    expect_out("rr_last_left", 0, 3, 1, 0);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv(); free = 1'b0; allocate = 1'b1;
    expect_out("rr_ptr_is_3", 0, 3, 1, 0);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv(); allocate = 1'b0;
    expect_out("rr_ptr_wrap", 0, 0, 1, 0);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv();
  endtask

  task automatic test_free_no_bypass();
    oport = 3'd1; allocate = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_out($sformatf("fill_p1_vc%0d", k), 0, k, 1, 0);
      @(negedge clock);
      while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
        if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
      adv();
    end
    allocate = 1'b0;
    expect_out("p1_full", 0, 0, 0, 0);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv(); free = 1'b1; free_oport = 3'd1; free_vc = 2'd2;
    expect_out("free_no_bypass", 0, 0, 0, 0);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv(); free = 1'b0;
    expect_out("freed_vc2_offered", 0, 2, 1, 0);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv();
  endtask

  task automatic test_credits();
    // Rows: send, credit_ret, expected vc, expected err (sampled before the edge).
    int rows [7][4] = '{'{1,0,0,0}, '{1,0,0,0}, '{0,0,1,0}, '{1,0,1,0},
                        '{0,1,1,1}, '{0,0,0,1}, '{0,0,0,1}};
    oport = 3'd0; send_oport = 3'd0; send_vc = 2'd0; cred_oport = 3'd0; cred_vc = 2'd0;
    for (int r = 0; r < 7; r++) begin
      send = rows[r][0][0]; credit_ret = rows[r][1][0];
      expect_out($sformatf("credit_step%0d", r), 0, rows[r][2], 1, rows[r][3][0]);
      @(negedge clock);
      while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
        if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
      adv();
    end
    clear_inputs();
  endtask

  task automatic test_credit_balance();
    do_reset(); oport = 3'd4;
    send = 1'b1; send_oport = 3'd4; send_vc = 2'd3;
    credit_ret = 1'b1; cred_oport = 3'd4; cred_vc = 2'd3;
    adv(); send = 1'b0;
    expect_out("bal_no_error", 0, 0, 1, 0);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv(); credit_ret = 1'b0;
    expect_out("cred_over_max", 0, 0, 1, 1);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv();
  endtask

  task automatic test_out_of_range();
    do_reset(); oport = 3'd5;
    expect_out("oport_5_invalid", 0, 0, 0, 0);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv(); oport = 3'd7; send = 1'b1; send_oport = 3'd5; send_vc = 2'd0;
    expect_out("oport_7_invalid", 0, 0, 0, 0);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv(); send = 1'b0; oport = 3'd0;
    expect_out("send_port5_error", 0, 0, 1, 1);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv();
  endtask

  task automatic test_static();
    do_reset(); oport = 3'd0; allocate = 1'b1;
    expect_out("st_first", 1, 0, 1, 0);
    expect_out("rr_first", 0, 0, 1, 0);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv(); allocate = 1'b0; free = 1'b1; free_oport = 3'd0; free_vc = 2'd0;
    expect_out("st_vc0_owned", 1, 1, 1, 0);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv(); free = 1'b0; allocate = 1'b1;
    expect_out("st_regrant_vc0", 1, 0, 1, 0);
    expect_out("rr_moves_on", 0, 1, 1, 0);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv(); allocate = 1'b0; free = 1'b1;
    adv(); free = 1'b0; mask[0] = 1'b0;
    expect_out("st_mask_bit0", 1, 1, 1, 0);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv();
  endtask

  task automatic test_enable_and_reset();
    do_reset(); oport = 3'd3; allocate = 1'b1;
    adv();
    enable = 1'b0; free = 1'b1; free_oport = 3'd3; free_vc = 2'd0;
    send = 1'b1; send_oport = 3'd3; send_vc = 2'd1;
    for (int k = 0; k < 3; k++) begin
      expect_out($sformatf("disabled%0d", k), 0, 1, 1, 0);
      @(negedge clock);
      while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
        if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
      adv();
    end
    clear_inputs();
    expect_out("held_after_enable", 0, 1, 1, 0);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv(); mask[15:13] = 3'b000;
    expect_out("vc0_still_owned", 0, 0, 0, 0);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv(); mask = '1; free = 1'b1; free_oport = 3'd3; free_vc = 2'd2;
    adv(); free = 1'b0;
    expect_out("free_unowned_err", 0, 1, 1, 1);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv(); #2 reset_n = 1'b0;
    expect_out("async_reset", 0, 0, 1, 0);
    @(negedge clock);
    while (exp_q.size() > 0) begin e = exp_q.pop_front(); n_assert++;
      if (obs(e.st) !== e.v) begin n_fail++; $display("FAIL %s: got %s, expected %s", e.name, fmt(obs(e.st)), fmt(e.v)); end end
    adv(); reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rr_alloc();
    test_free_no_bypass();
    test_credits();
    test_credit_balance();
    test_out_of_range();
    test_static();
    test_enable_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
